alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Sits on the operand side of the 4-bit ALU and issues its operations.
- Owns a small register file. Accepts register-addressed commands over a valid/ready handshake and drives A, B and Opcode into the combinational ALU.
- Captures the ALU result and the 5-bit flag vector, writes the result back and holds the flags in a status register (psr).
- Returns a response over a second valid/ready handshake.

Parameters:
- WIDTH, 4, datapath width; must match the ALU operand width.
- NREGS, 4, number of general registers; addressed by clog2(NREGS) bits.
- CNT_W, 8, width of the saturating retired-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer accepts the command this cycle.
- cmd_op  in  2  00 ADDU, 01 ADD, 10 SUB, 11 CMP.
- cmd_dst  in  2  destination register, also the A operand.
- cmd_src  in  2  B operand register.
- ld_en  in  1  direct register load.
- ld_addr  in  2  load target register.
- ld_data  in  WIDTH  load value.
- rd_addr  in  2  debug read address.
- rd_data  out  WIDTH  combinational read of R[rd_addr].
- alu_a  out  WIDTH  ALU operand A, registered.
- alu_b  out  WIDTH  ALU operand B, registered.
- alu_op  out  2  ALU opcode, registered.
- alu_c  in  WIDTH  ALU result.
- alu_flags  in  5  ALU flags: [4] Z, [3] carry, [2] overflow, [1] negative, [0] low.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  WIDTH  captured ALU result.
- psr  out  5  latched flags of the last completed operation.
- ops_count  out  CNT_W  retired operations, saturating.

Behaviour:
- Reset values: all registers 0; alu_a, alu_b, alu_op, rsp_result, psr, ops_count are 0; rsp_valid 0; state IDLE.
- Reset asserted in any state returns to IDLE in the next cycle. Any in-flight command is dropped: no writeback, no response.
- FSM states: IDLE, SETUP, CAPTURE, RESP.
- IDLE:
  - cmd_ready = !ld_en.
  - If ld_en, then R[ld_addr] <= ld_data; a load is 1 cycle and takes priority over a command in the same cycle.
  - If cmd_valid && cmd_ready, latch alu_a <= R[cmd_dst], alu_b <= R[cmd_src], alu_op <= cmd_op, and the dst index; go to SETUP.
  - When cmd_dst == cmd_src, A and B carry the same value.
- SETUP: one cycle to let the ALU settle; go to CAPTURE.
- CAPTURE:
  - rsp_result <= alu_c; psr <= alu_flags.
  - If op != CMP, R[dst] <= alu_c. CMP never writes a register.
  - ops_count increments and saturates at all-ones.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_result and psr are held stable.
  - Leave for IDLE on rsp_valid && rsp_ready.
- Latency: command accepted at edge N; writeback at edge N+2; rsp_valid high from cycle N+3. Minimum issue interval is 4 cycles.
- cmd_ready = 0 in every non-IDLE state.
- ld_en outside IDLE is ignored; no register changes.
- rd_data reflects a writeback on the cycle after the write edge; there is no bypass.
- Arithmetic: all WIDTH-bit; results wrap modulo 2^WIDTH, with carry and overflow reported only through the ALU flags. The sequencer never recomputes flags.
- psr holds its value between operations and does not change on loads.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants ADDU/ADD/SUB/CMP;
  - flag bit indices FLAG_Z=4, FLAG_C=3, FLAG_F=2, FLAG_N=1, FLAG_L=0;
  - the FSM state encoding.
- One natural sub-module: alu_regfile (NREGS x WIDTH, one synchronous write port, three combinational read ports for A, B and debug).
- Bench instantiates the sequencer with the existing ALU module bound to the alu_* ports.

Test Plan:
- Load R0=3, R1=5; ADDU dst=0 src=1 -> R0=8, rsp_result=8, psr=00000, ops_count=1.
- Load R2=F; R3=1; ADDU dst=2 src=3 -> R2=0, psr=11000 (Z and carry).
- Load R0=7, R1=1; ADD dst=0 src=1 -> R0=8, psr=00100 (overflow); then SUB dst=0 src=0 -> R0=0, psr[4]=1.
- Load R0=D (-3), R1=2; CMP dst=0 src=1 -> psr[1:0]=11, rsp_result=0, R0 still D. Also check that cmd_ready=0 while ld_en=1 in IDLE.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_valid, rsp_result and psr stable, cmd_ready=0, and a second cmd_valid is not accepted until the handshake completes.
- Assert reset during CAPTURE of ADDU 3+5 -> next cycle all registers, psr, ops_count and rsp_valid are 0, state IDLE, no writeback seen on rd_data.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag bit positions
// and the sequencer FSM encoding.
package alu_pkg;

    localparam logic [1:0] OP_ADDU = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETUP   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// General register file: one synchronous write port, three combinational read
// ports (operand A, operand B, debug). No write-to-read bypass.
module alu_regfile #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues register-addressed commands to a combinational ALU, writes results
// back, latches flags into psr and returns a response per command.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int CNT_W = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [4:0]       psr,
    output logic [CNT_W-1:0] ops_count
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [4:0]       psr_q, psr_d;
    logic [CNT_W-1:0] ops_count_q, ops_count_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] ra_data, rb_data;

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .ra_addr (cmd_dst),
        .rb_addr (cmd_src),
        .rd_addr (rd_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .rd_data (rd_data)
    );

    // Loads win over commands; the handshake only completes when no load is pending.
    assign cmd_ready = (state_q == ST_IDLE) && !ld_en;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        dst_d        = dst_q;
        rsp_result_d = rsp_result_q;
        psr_d        = psr_q;
        ops_count_d  = ops_count_q;
        rsp_valid_d  = rsp_valid_q;
        rf_we        = 1'b0;
        rf_waddr     = ld_addr;
        rf_wdata     = ld_data;
        case (state_q)
            ST_IDLE: begin
                if (ld_en) begin
                    rf_we = 1'b1;
                end else if (cmd_valid) begin
                    alu_a_d  = ra_data;
                    alu_b_d  = rb_data;
                    alu_op_d = cmd_op;
                    dst_d    = cmd_dst;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rsp_result_d = alu_c;
                psr_d        = alu_flags;
                if (alu_op_q != OP_CMP) begin
                    rf_we    = 1'b1;
                    rf_waddr = dst_q;
                    rf_wdata = alu_c;
                end
                if (ops_count_q != {CNT_W{1'b1}}) begin
                    ops_count_d = ops_count_q + CNT_W'(1);
                end
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            dst_q        <= '0;
            rsp_result_q <= '0;
            psr_q        <= '0;
            ops_count_q  <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            dst_q        <= dst_d;
            rsp_result_q <= rsp_result_d;
            psr_q        <= psr_d;
            ops_count_q  <= ops_count_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign psr        = psr_q;
    assign ops_count  = ops_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a combinational 4-bit ALU model sits on the
// alu_* ports; directed vectors plus hand sequences for backpressure and reset.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op, cmd_dst, cmd_src;
    logic             ld_en;
    logic [1:0]       ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [1:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] alu_a, alu_b, alu_c;
    logic [1:0]       alu_op;
    logic [4:0]       alu_flags;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [4:0]       psr;
    logic [CNT_W-1:0] ops_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .NREGS(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .psr(psr), .ops_count(ops_count)
    );

    // ALU model: CMP sets N on signed A<B and L on unsigned A>B, result 0.
    logic [WIDTH:0] alu_tmp;
    always_comb begin
        alu_tmp   = '0;
        alu_c     = '0;
        alu_flags = '0;
        case (alu_op)
            OP_ADDU, OP_ADD: begin
                alu_tmp           = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c             = alu_tmp[WIDTH-1:0];
                alu_flags[FLAG_C] = alu_tmp[WIDTH];
                if (alu_op == OP_ADD)
                    alu_flags[FLAG_F] = (alu_a[3] == alu_b[3]) && (alu_c[3] != alu_a[3]);
                alu_flags[FLAG_Z] = (alu_c == '0);
            end
            OP_SUB: begin
                alu_tmp           = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c             = alu_tmp[WIDTH-1:0];
                alu_flags[FLAG_C] = alu_tmp[WIDTH];
                alu_flags[FLAG_F] = (alu_a[3] != alu_b[3]) && (alu_c[3] != alu_a[3]);
                alu_flags[FLAG_Z] = (alu_c == '0);
            end
            default: begin
                alu_flags[FLAG_Z] = (alu_a == alu_b);
                alu_flags[FLAG_N] = ($signed(alu_a) < $signed(alu_b));
                alu_flags[FLAG_L] = (alu_a > alu_b);
            end
        endcase
    end

    typedef struct {
        logic       do_load;
        logic [1:0] op, dst, src;
        logic [3:0] a, b;
        logic [3:0] exp_res;
        logic [4:0] exp_psr;
        logic [3:0] exp_rd;
        logic [7:0] exp_ops;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_reg(input logic [1:0] addr, input logic [3:0] val);
        ld_en = 1'b1; ld_addr = addr; ld_data = val;
        #1;
        check("cmd_ready_during_ld", cmd_ready, 0);
        @(posedge clk); #1;
        ld_en = 1'b0;
        rd_addr = addr;
        #1;
        check("ld_readback", rd_data, val);
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_rsp();
        int lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", lat, 2);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, OP_ADDU, 2'd0, 2'd1, 4'h3, 4'h5, 4'h8, 5'b00000, 4'h8, 8'd1};
        vecs[1] = '{1'b1, OP_ADDU, 2'd2, 2'd3, 4'hF, 4'h1, 4'h0, 5'b11000, 4'h0, 8'd2};
        vecs[2] = '{1'b1, OP_ADD,  2'd0, 2'd1, 4'h7, 4'h1, 4'h8, 5'b00100, 4'h8, 8'd3};
        vecs[3] = '{1'b0, OP_SUB,  2'd0, 2'd0, 4'h0, 4'h0, 4'h0, 5'b10000, 4'h0, 8'd4};
        vecs[4] = '{1'b1, OP_CMP,  2'd0, 2'd1, 4'hD, 4'h2, 4'h0, 5'b00011, 4'hD, 8'd5};
        vecs[5] = '{1'b1, OP_ADDU, 2'd1, 2'd1, 4'h6, 4'h6, 4'hC, 5'b00000, 4'hC, 8'd6};
        vecs[6] = '{1'b1, OP_SUB,  2'd3, 2'd2, 4'h2, 4'h5, 4'hD, 5'b01000, 4'hD, 8'd7};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_psr", psr, 0);
        check("reset_ops_count", ops_count, 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_op", alu_op, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        for (int r = 0; r < 4; r++) begin
            rd_addr = r[1:0]; #1;
            check("reset_reg", rd_data, 0);
        end

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_load) begin
                load_reg(vecs[i].dst, vecs[i].a);
                if (vecs[i].src != vecs[i].dst) load_reg(vecs[i].src, vecs[i].b);
            end
            issue(vecs[i].op, vecs[i].dst, vecs[i].src);
            wait_rsp();
            check("vec_result", rsp_result, vecs[i].exp_res);
            check("vec_psr", psr, vecs[i].exp_psr);
            check("vec_ops_count", ops_count, vecs[i].exp_ops);
            finish_rsp();
            rd_addr = vecs[i].dst; #1;
            check("vec_dst_reg", rd_data, vecs[i].exp_rd);
        end

        // Writeback timing and backpressure in RESP
        load_reg(2'd0, 4'h4);
        load_reg(2'd1, 4'h9);
        issue(OP_ADDU, 2'd0, 2'd1);
        rd_addr = 2'd0;
        @(posedge clk); #1;
        check("wb_not_before_capture", rd_data, 4'h4);
        @(posedge clk); #1;
        check("wb_after_capture", rd_data, 4'hD);
        check("bp_rsp_valid_first", rsp_valid, 1);
        cmd_valid = 1'b1; cmd_op = OP_ADDU; cmd_dst = 2'd1; cmd_src = 2'd1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_result", rsp_result, 4'hD);
            check("bp_psr", psr, 5'b00000);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_ops_count", ops_count, 8'd8);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_second_accepted", cmd_ready, 0);
        wait_rsp();
        check("bp_second_result", rsp_result, 4'h2);
        check("bp_second_psr", psr, 5'b01000);
        check("bp_second_ops", ops_count, 8'd9);
        finish_rsp();
        rd_addr = 2'd1; #1;
        check("bp_second_reg", rd_data, 4'h2);
        rd_addr = 2'd0; #1;
        check("bp_first_reg", rd_data, 4'hD);

        // psr survives loads
        load_reg(2'd3, 4'h7);
        check("psr_hold_on_load", psr, 5'b01000);

        // Counter saturation: 250 more ops from 9
        for (int n = 0; n < 250; n++) begin
            issue(OP_CMP, 2'd0, 2'd0);
            wait_rsp();
            finish_rsp();
        end
        check("ops_count_saturated", ops_count, 8'hFF);
        check("cmp_equal_psr", psr, 5'b10000);

        // Reset during CAPTURE drops the command
        load_reg(2'd0, 4'h3);
        load_reg(2'd1, 4'h5);
        issue(OP_ADDU, 2'd0, 2'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_cap_rsp_valid", rsp_valid, 0);
        check("rst_cap_psr", psr, 0);
        check("rst_cap_ops_count", ops_count, 0);
        check("rst_cap_rsp_result", rsp_result, 0);
        check("rst_cap_alu_a", alu_a, 0);
        check("rst_cap_cmd_ready", cmd_ready, 1);
        rd_addr = 2'd1; #1;
        check("rst_cap_r1", rd_data, 0);
        rd_addr = 2'd0; #1;
        check("rst_cap_r0", rd_data, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cap_no_late_rsp", rsp_valid, 0);
        check("rst_cap_no_late_wb", rd_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
